// File: rtl/note_pkg.sv
// Shared note definitions: one_hot_Note field positions, tone and octave codes,
// transmit FSM state encoding and the note-to-byte encoder.
package note_pkg;

    localparam int NOTE_W        = 10;
    localparam int NOTE_TONE_LSB = 0;
    localparam int NOTE_TONE_MSB = 6;
    localparam int NOTE_HIGH     = 7;
    localparam int NOTE_LOW      = 8;
    localparam int NOTE_SHARP    = 9;

    localparam logic [2:0] TONE_REST = 3'd0;
    localparam logic [2:0] TONE_DO   = 3'd1;
    localparam logic [2:0] TONE_RE   = 3'd2;
    localparam logic [2:0] TONE_MI   = 3'd3;
    localparam logic [2:0] TONE_FA   = 3'd4;
    localparam logic [2:0] TONE_SO   = 3'd5;
    localparam logic [2:0] TONE_LA   = 3'd6;
    localparam logic [2:0] TONE_SI   = 3'd7;

    localparam logic [1:0] OCT_MID  = 2'b00;
    localparam logic [1:0] OCT_HIGH = 2'b01;
    localparam logic [1:0] OCT_LOW  = 2'b10;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Lowest set tone bit wins; high octave wins over low octave.
    function automatic logic [7:0] encode_note(input logic [NOTE_W-1:0] n);
        logic [2:0] tone;
        logic [1:0] oct;
        tone = TONE_REST;
        for (int i = NOTE_TONE_MSB; i >= NOTE_TONE_LSB; i--) begin
            if (n[i]) tone = 3'(i + 1);
        end
        if (n[NOTE_HIGH])     oct = OCT_HIGH;
        else if (n[NOTE_LOW]) oct = OCT_LOW;
        else                  oct = OCT_MID;
        return {2'b00, n[NOTE_SHARP], oct, tone};
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmit engine: FSM, baud counter, shift register and optional parity.
// Ports: clk, rst (async active-low), avail/din (byte source), pop, tx, active.
// NOTE_TX_PARITY_EN adds an even-parity bit between data and stop bits.
module uart_tx_core
    import note_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       avail,
    input  logic [7:0] din,
    output logic       pop,
    output logic       tx,
    output logic       active
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    tx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    sh, sh_d;
    logic          par, par_d;
    logic          tx_d;
    logic          tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            sh    <= sh_d;
            par   <= par_d;
            tx    <= tx_d;
        end
    end

    assign tick = (cnt == '0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        sh_d    = sh;
        par_d   = par;
        pop     = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (avail) begin
                    pop     = 1'b1;
                    sh_d    = din;
                    par_d   = ^din;
                    cnt_d   = RELOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    idx_d   = '0;
                    cnt_d   = RELOAD;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    cnt_d = RELOAD;
                    if (idx == 3'd7) begin
`ifdef NOTE_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        idx_d = idx + 3'd1;
                        sh_d  = sh >> 1;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    cnt_d   = RELOAD;
                    state_d = TX_STOP;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (!tick) begin
                    cnt_d = cnt - 1'b1;
                end else if (avail) begin
                    // Back-to-back frame: no idle bit between stop and start.
                    pop     = 1'b1;
                    sh_d    = din;
                    par_d   = ^din;
                    cnt_d   = RELOAD;
                    state_d = TX_START;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // tx is registered from the next state so the line never glitches.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = sh_d[0];
            TX_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign active = (state != TX_IDLE);

endmodule

// File: rtl/note_uart_tx.sv
// Note-change UART transmitter: detects one_hot_Note changes, encodes them to
// bytes, queues them in a FIFO and sends them through uart_tx_core.
// Ports: clk, rst (async active-low), enable, one_hot_Note[9:0], tx, busy,
// overflow (sticky drop flag), overflow_clr. Option macro: NOTE_TX_PARITY_EN.
module note_uart_tx
    import note_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NOTE_W-1:0] one_hot_Note,
    output logic              tx,
    output logic              busy,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;

    logic [NOTE_W-1:0] prev_note;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [7:0]        enc;
    logic              change, full, avail;
    logic              push, pop, drop, active;

    assign change = enable && (prev_note != one_hot_Note);
    assign enc    = encode_note(one_hot_Note);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign avail  = (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_note <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            prev_note <= one_hot_Note;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    uart_tx_core #(
        .DIV (DIV)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .avail  (avail),
        .din    (mem[rd_ptr]),
        .pop    (pop),
        .tx     (tx),
        .active (active)
    );

    assign busy = active || avail;

endmodule

// File: tb/tb_note_uart_tx.sv
// Self-checking bench for note_uart_tx: directed and random note changes,
// line decoding monitor and a reference encoder built from plain arithmetic.
module tb_note_uart_tx;

    localparam int CF    = 1000;
    localparam int BD    = 100;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;
`ifdef NOTE_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [9:0] note = '0;
    logic       tx, busy, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_rx = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q[$];
    int starts[$];

    note_uart_tx #(
        .CLK_FREQ   (CF),
        .BAUD       (BD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .one_hot_Note (note),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [9:0] n);
        int tone;
        int oct;
        tone = 0;
        for (int i = 0; i < 7; i++) begin
            if (n[i]) begin
                tone = i + 1;
                break;
            end
        end
        oct = n[7] ? 1 : (n[8] ? 2 : 0);
        return 8'(tone + 8 * oct + 32 * int'(n[9]));
    endfunction

    task automatic wait_idle(input int lim);
        int k;
        repeat (2) @(negedge clk);
        k = 0;
        while (busy !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(k < lim), 32'd1);
    endtask

    // Line monitor: samples each bit in its middle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx === 1'b0) begin
                logic [7:0] d;
                int st;
                st = cyc;
                repeat (DIV / 2) @(negedge clk);
                chk("start_bit", 32'(tx), 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) @(negedge clk);
                    d[b] = tx;
                end
`ifdef NOTE_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                chk("parity_bit", 32'(tx), 32'(^d));
`endif
                repeat (DIV) @(negedge clk);
                chk("stop_bit", 32'(tx), 32'd1);
                starts.push_back(st);
                n_rx++;
                if (exp_q.size() == 0)
                    chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                else
                    chk("rx_byte", 32'(d), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [9:0] nn;
        int base;
        int lows;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // mi, mid octave -> 0x03; latency and frame length
        note = 10'b0000000100;
        exp_q.push_back(ref_byte(note));
        @(posedge clk); #1;
        chk("push_edge_tx", 32'(tx), 32'd1);
        chk("push_edge_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("start_edge_tx", 32'(tx), 32'd0);
        repeat (FRAME - 1) @(posedge clk);
        #1;
        chk("last_cycle_busy", 32'(busy), 32'd1);
        chk("last_cycle_tx", 32'(tx), 32'd1);
        @(posedge clk); #1;
        chk("frame_end_busy", 32'(busy), 32'd0);
        wait_idle(50);
        chk("mi_frames", 32'(n_rx), 32'd1);
        chk("mi_value", 32'(ref_byte(10'b0000000100)), 32'h03);

        // do, high octave, sharp -> 0x29
        @(negedge clk);
        note = 10'b1010000001;
        exp_q.push_back(ref_byte(note));
        wait_idle(FRAME + 50);
        chk("do_hi_sharp_value", 32'(ref_byte(10'b1010000001)), 32'h29);

        // random notes, enable sometimes dropped mid-frame
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            do nn = 10'($urandom); while (nn == note);
            note = nn;
            exp_q.push_back(ref_byte(nn));
            repeat (3) @(negedge clk);
            enable = 1'($urandom_range(0, 1));
            wait_idle(FRAME + 50);
            enable = 1'b1;
        end
        chk("random_frames", 32'(n_rx), 32'd10);
        chk("random_queue_empty", 32'(exp_q.size()), 32'd0);

        // changes with enable low, then enable with unchanged note
        base = n_rx;
        @(negedge clk);
        enable = 1'b0;
        note = ~note;
        @(negedge clk);
        note = 10'h000;
        repeat (30) @(negedge clk);
        chk("disabled_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        repeat (30) @(negedge clk);
        chk("reenable_busy", 32'(busy), 32'd0);
        chk("no_frame_frames", 32'(n_rx - base), 32'd0);

        // six changes on consecutive cycles into a 4-deep FIFO
        base = n_rx;
        starts.delete();
        for (int i = 0; i < 6; i++) begin
            note = 10'(32'h080 | (32'd1 << i));
            if (i < 5) exp_q.push_back(ref_byte(note));
            @(negedge clk);
        end
        chk("burst_overflow", 32'(overflow), 32'd1);
        wait_idle(5 * FRAME + 50);
        chk("burst_frames", 32'(n_rx - base), 32'd5);
        for (int i = 1; i < 5; i++)
            chk("burst_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
        chk("overflow_sticky", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("overflow_cleared", 32'(overflow), 32'd0);

        // reset in the middle of data bit 3 (la -> 0x06, bit3 = 0)
        mon_en = 1'b0;
        note = 10'b0000100000;
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort_start_tx", 32'(tx), 32'd0);
        repeat (DIV + 3 * DIV + DIV / 2) @(posedge clk);
        @(negedge clk);
        chk("abort_bit3_tx", 32'(tx), 32'd0);
        rst = 1'b0;
        note = 10'h000;
        #1;
        chk("abort_tx_async", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("abort_no_edges", 32'(lows), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        // transmission resumes cleanly on the next change
        mon_en = 1'b1;
        base = n_rx;
        enable = 1'b1;
        note = 10'b0101000000;
        exp_q.push_back(ref_byte(note));
        wait_idle(FRAME + 50);
        chk("after_abort_frames", 32'(n_rx - base), 32'd1);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
